// File: rtl/apu_cluster_arbiter.sv
// Round-robin arbiter that shares one APU between NUM_CORES dispatchers, with a
// grant lock and an in-order tag FIFO that routes each result to its issuing core.
module apu_cluster_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int TAG_DEPTH = 4,
  parameter int WARGS     = 96,
  parameter int WOP       = 6,
  parameter int WRES      = 32,
  parameter int WFLAGS    = 5
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NUM_CORES-1:0]       core_req_i,
  output logic [NUM_CORES-1:0]       core_gnt_o,
  input  logic [NUM_CORES*WARGS-1:0] core_args_i,
  input  logic [NUM_CORES*WOP-1:0]   core_op_i,
  output logic [NUM_CORES-1:0]       core_rvalid_o,
  output logic [WRES-1:0]            core_result_o,
  output logic [WFLAGS-1:0]          core_flags_o,
  output logic                       apu_req_o,
  input  logic                       apu_gnt_i,
  output logic [WARGS-1:0]           apu_args_o,
  output logic [WOP-1:0]             apu_op_o,
  input  logic                       apu_rvalid_i,
  input  logic [WRES-1:0]            apu_result_i,
  input  logic [WFLAGS-1:0]          apu_flags_i,
  output logic                       busy_o,
  output logic                       err_o,
  output logic [15:0]                contention_cnt_o
);

  localparam int IDW = $clog2(NUM_CORES);
  localparam int PW  = $clog2(TAG_DEPTH);
  localparam int CW  = PW + 1;
  localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_CORES - 1);

  logic [IDW-1:0] rr_ptr;
  logic           lock_valid;
  logic [IDW-1:0] lock_id;
  logic [IDW-1:0] tag_fifo [TAG_DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           err;
  logic [15:0]    contention_cnt;

  logic [IDW-1:0] winner;
  logic [IDW-1:0] search_id;
  logic           found;
  logic           fifo_full;
  logic           fifo_empty;
  logic           handshake;
  logic           pop;
  logic           multi_req;

  assign fifo_full  = (count == CW'(TAG_DEPTH));
  assign fifo_empty = (count == '0);
  assign apu_req_o  = (|core_req_i) & ~fifo_full;
  assign handshake  = apu_req_o & apu_gnt_i;
  assign pop        = apu_rvalid_i & ~fifo_empty;
  assign multi_req  = ($countones(core_req_i) > 1);

  // A held lock overrides the round-robin search so a pending request never moves.
  always_comb begin
    search_id = rr_ptr;
    winner    = rr_ptr;
    found     = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (!found && core_req_i[search_id]) begin
        winner = search_id;
        found  = 1'b1;
      end
      search_id = (search_id == LAST_ID) ? '0 : search_id + 1'b1;
    end
    if (lock_valid) begin
      winner = lock_id;
    end
  end

  always_comb begin
    apu_args_o    = '0;
    apu_op_o      = '0;
    core_gnt_o    = '0;
    core_rvalid_o = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (winner == IDW'(i)) begin
        apu_args_o    = core_args_i[i*WARGS +: WARGS];
        apu_op_o      = core_op_i[i*WOP +: WOP];
        core_gnt_o[i] = handshake;
      end
      if (tag_fifo[rd_ptr] == IDW'(i)) begin
        core_rvalid_o[i] = pop;
      end
    end
  end

  assign core_result_o    = apu_result_i;
  assign core_flags_o     = apu_flags_i;
  assign busy_o           = ~fifo_empty;
  assign err_o            = err;
  assign contention_cnt_o = contention_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr     <= '0;
      lock_valid <= 1'b0;
      lock_id    <= '0;
    end else if (handshake) begin
      rr_ptr     <= (winner == LAST_ID) ? '0 : winner + 1'b1;
      lock_valid <= 1'b0;
    end else if (apu_req_o) begin
      lock_valid <= 1'b1;
      lock_id    <= winner;
    end
  end

  // Tag payload needs no reset; only the pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (handshake) begin
      tag_fifo[wr_ptr] <= winner;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (handshake) wr_ptr <= wr_ptr + 1'b1;
      if (pop)       rd_ptr <= rd_ptr + 1'b1;
      case ({handshake, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err            <= 1'b0;
      contention_cnt <= '0;
    end else begin
      if (apu_rvalid_i && fifo_empty) err <= 1'b1;
      if (multi_req && contention_cnt != 16'hFFFF) begin
        contention_cnt <= contention_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apu_cluster_arbiter.sv
// Randomized bench for apu_cluster_arbiter; a queue-based reference model predicts
// grants, routing, busy/err and the contention counter every cycle.
module tb_apu_cluster_arbiter;

  localparam int N      = 4;
  localparam int D      = 4;
  localparam int WARGS  = 96;
  localparam int WOP    = 6;
  localparam int WRES   = 32;
  localparam int WFLAGS = 5;

  logic                   clk;
  logic                   rst_n;
  logic [N-1:0]           core_req;
  logic [N-1:0]           core_gnt;
  logic [N*WARGS-1:0]     core_args;
  logic [N*WOP-1:0]       core_op;
  logic [N-1:0]           core_rvalid;
  logic [WRES-1:0]        core_result;
  logic [WFLAGS-1:0]      core_flags;
  logic                   apu_req;
  logic                   apu_gnt;
  logic [WARGS-1:0]       apu_args;
  logic [WOP-1:0]         apu_op;
  logic                   apu_rvalid;
  logic [WRES-1:0]        apu_result;
  logic [WFLAGS-1:0]      apu_flags;
  logic                   busy;
  logic                   err;
  logic [15:0]            cont_cnt;

  apu_cluster_arbiter #(
    .NUM_CORES(N), .TAG_DEPTH(D), .WARGS(WARGS), .WOP(WOP), .WRES(WRES), .WFLAGS(WFLAGS)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .core_req_i(core_req), .core_gnt_o(core_gnt),
    .core_args_i(core_args), .core_op_i(core_op),
    .core_rvalid_o(core_rvalid), .core_result_o(core_result), .core_flags_o(core_flags),
    .apu_req_o(apu_req), .apu_gnt_i(apu_gnt), .apu_args_o(apu_args), .apu_op_o(apu_op),
    .apu_rvalid_i(apu_rvalid), .apu_result_i(apu_result), .apu_flags_i(apu_flags),
    .busy_o(busy), .err_o(err), .contention_cnt_o(cont_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus knobs and per-core held requests
  logic [WARGS-1:0] args_q [N];
  logic [WOP-1:0]   op_q [N];
  bit               pending [N];
  logic [N-1:0]     req_mask;
  int               p_req, p_gnt, p_rv;
  bit               force_rv, use_fixed;
  logic [WRES-1:0]  fixed_result;

  // Reference model
  int m_rr, m_lock_id, m_cnt;
  bit m_lock, m_err;
  int tag_q [$];
  bit exp_req;
  int exp_w;
  logic [N-1:0] exp_gnt, exp_rv;

  int error_count, check_count;

  task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic int modelWinner();
    if (m_lock) return m_lock_id;
    for (int k = 0; k < N; k++) begin
      if (core_req[(m_rr + k) % N]) return (m_rr + k) % N;
    end
    return 0;
  endfunction

  task automatic applyStimulus();
    for (int c = 0; c < N; c++) begin
      if (!pending[c] && req_mask[c] && ($urandom_range(99) < p_req)) begin
        pending[c] = 1'b1;
        op_q[c]    = WOP'($urandom());
        args_q[c]  = {$urandom(), $urandom(), $urandom()};
      end
      core_req[c] = pending[c];
      core_args[c*WARGS +: WARGS] = args_q[c];
      core_op[c*WOP +: WOP] = op_q[c];
    end
    apu_gnt    = ($urandom_range(99) < p_gnt);
    apu_rvalid = force_rv || (tag_q.size() > 0 && $urandom_range(99) < p_rv);
    apu_result = use_fixed ? fixed_result : $urandom();
    apu_flags  = WFLAGS'($urandom());
    #1;
    exp_w   = modelWinner();
    exp_req = (core_req != '0) && (tag_q.size() < D);
    exp_gnt = (exp_req && apu_gnt) ? (N'(1) << exp_w) : '0;
    exp_rv  = (apu_rvalid && tag_q.size() > 0) ? (N'(1) << tag_q[0]) : '0;
    checkOutput("apu_req", apu_req, exp_req);
    checkOutput("core_gnt", core_gnt, exp_gnt);
    checkOutput("core_rvalid", core_rvalid, exp_rv);
    checkOutput("core_result", core_result, apu_result);
    checkOutput("core_flags", core_flags, apu_flags);
    checkOutput("busy", busy, tag_q.size() != 0);
    checkOutput("err", err, m_err);
    checkOutput("cont_cnt", cont_cnt, m_cnt);
    if (exp_req) begin
      checkOutput("apu_op", apu_op, op_q[exp_w]);
      checkOutput("apu_args", apu_args, args_q[exp_w]);
    end
  endtask

  task automatic stepClock();
    @(posedge clk);
    if (apu_rvalid) begin
      if (tag_q.size() > 0) void'(tag_q.pop_front());
      else m_err = 1'b1;
    end
    if (exp_req && apu_gnt) begin
      tag_q.push_back(exp_w);
      m_rr = (exp_w + 1) % N;
      m_lock = 1'b0;
      pending[exp_w] = 1'b0;
    end else if (exp_req) begin
      m_lock = 1'b1;
      m_lock_id = exp_w;
    end
    if ($countones(core_req) >= 2 && m_cnt < 16'hFFFF) m_cnt++;
    @(negedge clk);
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    for (int c = 0; c < N; c++) pending[c] = 1'b0;
    core_req = '0;
    apu_gnt = 1'b0;
    apu_rvalid = 1'b0;
    force_rv = 1'b0;
    use_fixed = 1'b0;
    req_mask = '0;
    m_rr = 0; m_lock = 1'b0; m_lock_id = 0; m_err = 1'b0; m_cnt = 0;
    tag_q.delete();
    #1;
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_err", err, 1'b0);
    checkOutput("rst_cnt", cont_cnt, 16'h0);
    checkOutput("rst_apu_req", apu_req, 1'b0);
    checkOutput("rst_gnt", core_gnt, '0);
    checkOutput("rst_rvalid", core_rvalid, '0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    error_count = 0;
    check_count = 0;
    rst_n = 1'b0;
    core_req = '0; core_args = '0; core_op = '0;
    apu_gnt = 1'b0; apu_rvalid = 1'b0; apu_result = '0; apu_flags = '0;
    fixed_result = '0;
    for (int c = 0; c < N; c++) begin
      args_q[c] = '0;
      op_q[c] = '0;
    end
    @(negedge clk);

    // Round-robin with all cores requesting and a two-cycle APU
    resetDut();
    req_mask = 4'b1111; p_req = 100; p_gnt = 100;
    for (int i = 0; i < 8; i++) begin
      p_rv = (i >= 2) ? 100 : 0;
      applyStimulus();
      checkOutput("rr_gnt", core_gnt, N'(1) << (i % 4));
      if (i >= 2) checkOutput("rr_rvalid", core_rvalid, N'(1) << ((i - 2) % 4));
      stepClock();
    end

    // Lock holds core 2 while core 1 joins
    resetDut();
    req_mask = 4'b0100; p_req = 100; p_gnt = 0; p_rv = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) req_mask = 4'b0110;
      if (i == 3) p_gnt = 100;
      applyStimulus();
      if (i <= 3) checkOutput("lock_op", apu_op, op_q[2]);
      if (i == 3) checkOutput("lock_gnt2", core_gnt, 4'b0100);
      if (i == 4) checkOutput("lock_gnt1", core_gnt, 4'b0010);
      stepClock();
    end

    // Full tag FIFO blocks issue until a response frees a slot
    resetDut();
    req_mask = 4'b1111; p_req = 100; p_gnt = 100; p_rv = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      stepClock();
    end
    applyStimulus();
    checkOutput("full_req", apu_req, 1'b0);
    checkOutput("full_busy", busy, 1'b1);
    stepClock();
    p_rv = 100;
    applyStimulus();
    checkOutput("full_nobypass", apu_req, 1'b0);
    stepClock();
    p_rv = 0;
    applyStimulus();
    checkOutput("full_reopen", apu_req, 1'b1);
    stepClock();

    // Routing of 3,0,3 with fixed results
    resetDut();
    p_req = 100; p_gnt = 100; p_rv = 0;
    for (int i = 0; i < 3; i++) begin
      req_mask = (i == 1) ? 4'b0001 : 4'b1000;
      applyStimulus();
      checkOutput("route_gnt", core_gnt, (i == 1) ? 4'b0001 : 4'b1000);
      stepClock();
    end
    req_mask = '0; p_rv = 100; use_fixed = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fixed_result = WRES'(32'hA + i);
      applyStimulus();
      checkOutput("route_rvalid", core_rvalid, (i == 1) ? 4'b0001 : 4'b1000);
      checkOutput("route_result", core_result, 32'hA + i);
      stepClock();
    end
    use_fixed = 1'b0;

    // Spurious response, then reset with work in flight
    resetDut();
    p_req = 100; p_gnt = 100; p_rv = 0; force_rv = 1'b1;
    applyStimulus();
    checkOutput("err_no_rvalid", core_rvalid, '0);
    stepClock();
    force_rv = 1'b0;
    applyStimulus();
    checkOutput("err_set", err, 1'b1);
    stepClock();
    req_mask = 4'b0011;
    for (int i = 0; i < 2; i++) begin
      applyStimulus();
      stepClock();
    end
    req_mask = '0;
    p_gnt = 0;
    applyStimulus();
    checkOutput("inflight_busy", busy, 1'b1);
    resetDut();
    req_mask = 4'b1111; p_gnt = 100;
    applyStimulus();
    checkOutput("post_rst_gnt", core_gnt, 4'b0001);
    stepClock();

    // Contention counting and saturation
    resetDut();
    req_mask = 4'b0011; p_req = 100; p_gnt = 0; p_rv = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus();
      stepClock();
    end
    applyStimulus();
    checkOutput("cont_ten", cont_cnt, 16'd10);
    stepClock();
    force dut.contention_cnt = 16'hFFFD;
    #1;
    release dut.contention_cnt;
    m_cnt = 16'hFFFD;
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      stepClock();
    end
    applyStimulus();
    checkOutput("cont_sat", cont_cnt, 16'hFFFF);
    stepClock();

    // Long randomized run
    resetDut();
    req_mask = 4'b1111; p_req = 40; p_rv = 45;
    for (int i = 0; i < 2000; i++) begin
      if (i % 100 == 0) p_gnt = $urandom_range(20, 100);
      force_rv = ($urandom_range(199) == 0);
      applyStimulus();
      stepClock();
    end

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
